axi_burst_regfile: RTL and testbench
====================================

// Module: axi_burst_regfile
// PURPOSE: AXI4 slave register bank, parametrised in width/depth/ID; full FIXED/INCR/WRAP bursts on both write and read.
//   Independent write (AW/W/B) and read (AR/R) engines; out-of-range words return SLVERR. Sits under the AXI interconnect as the counter/control register target.
// PARAMETERS: DATA_WIDTH=32 bus width, multiple of 8 | ADDR_WIDTH=32 byte address width | REG_COUNT=8 number of DATA_WIDTH-bit registers | ID_WIDTH=4 transaction ID width
// PORTS:
//   clk       in   1               clock, all logic on posedge
//   areset    in   1               asynchronous reset, active-high
//   awid_i    in   ID_WIDTH        write ID
//   awaddr_i  in   ADDR_WIDTH      write start byte address
//   awlen_i   in   8               beats-1
//   awburst_i in   2               00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//   awvalid_i in   1               AW valid
//   awready_o out  1               AW ready
//   wdata_i   in   DATA_WIDTH      write data
//   wstrb_i   in   DATA_WIDTH/8    byte enables
//   wlast_i   in   1               last beat (informational)
//   wvalid_i  in   1               W valid
//   wready_o  out  1               W ready
//   bid_o     out  ID_WIDTH        = captured awid
//   bresp_o   out  2               00 OKAY, 10 SLVERR
//   bvalid_o  out  1               B valid
//   bready_i  in   1               B ready
//   arid_i    in   ID_WIDTH        read ID
//   araddr_i  in   ADDR_WIDTH      read start byte address
//   arlen_i   in   8               beats-1
//   arburst_i in   2               burst type, encoding as awburst_i
//   arvalid_i in   1               AR valid
//   arready_o out  1               AR ready
//   rid_o     out  ID_WIDTH        = captured arid
//   rdata_o   out  DATA_WIDTH      read data
//   rresp_o   out  2               per-beat response
//   rlast_o   out  1               last read beat
//   rvalid_o  out  1               R valid
//   rready_i  in   1               R ready
// BEHAVIOUR:
//   - Reset: registers=0; awready_o=arready_o=1; wready_o, bvalid_o, rvalid_o, rlast_o=0; bid/rid/bresp/rresp/rdata=0. Reset mid-burst aborts it, no response issued.
//   - Full-width beats only (no size port). Word index = addr[ADDR_WIDTH-1:$clog2(DATA_WIDTH/8)]; index >= REG_COUNT -> beat errors.
//   - Write FSM W_IDLE(awready=1) -AW hs-> W_DATA(wready=1) -beat awlen hs-> W_RESP(bvalid=1) -bready-> W_IDLE. wready 1 cycle after AW hs; bvalid 1 cycle after last beat.
//   - Burst end set by beat counter == awlen; wlast_i not used for termination. Each W hs writes strobed bytes when in range; errored beats write nothing.
//   - bresp = SLVERR if any beat errored or burst=11, else OKAY. Burst 11: no writes, beats still accepted.
//   - Read FSM R_IDLE(arready=1) -AR hs-> R_DATA(rvalid=1) -hs with rlast-> R_IDLE. rvalid 1 cycle after AR hs; one beat per cycle while rready=1; rdata/rresp/rlast held stable while rvalid && !rready.
//   - Errored read beat: rdata=0, rresp=SLVERR. rlast=1 exactly on beat arlen.
//   - Address step: FIXED holds; INCR +1 word, wraps modulo 2^(ADDR_WIDTH) silently; WRAP len in {1,3,7,15}, wraps at (len+1)-word aligned boundary; other WRAP len -> SLVERR all beats.
//   - Same-cycle write and read of one register: read returns old value, new value visible next cycle.
// CONFIGURATION: AXI_REGS_WRAP_EN defined -> WRAP bursts as above. Undefined -> WRAP treated like reserved 11:
//   write beats accepted and dropped with SLVERR; read beats return 0/SLVERR; no wrap logic synthesised.
// STRUCTURE: package axi_regs_pkg: burst_e (FIXED/INCR/WRAP/RSVD), RESP_OKAY/RESP_SLVERR, wr_state_e, rd_state_e.
//   Sub-module axi_burst_addr_gen (cur index, burst, len -> next index, wrap boundary), instantiated once per engine.
// TESTING (DATA_WIDTH=32, REG_COUNT=8):
//   - INCR write addr 0x0 len 3 data 1,2,3,4 strb F -> regs0..3=1..4, bresp OKAY bid=awid; INCR read same -> 1,2,3,4, rlast on 4th.
//   - WRAP write addr 0x8 len 3 data A,B,C,D -> reg2=A reg3=B reg0=C reg1=D; without macro -> no change, bresp=10.
//   - Write addr 0x1C len 1 -> reg7 written, beat 2 index 8 dropped, bresp=10; read addr 0x20 len 0 -> rdata 0 rresp 10.
//   - FIXED write addr 0x4 strb 3 then C, data 0x1111_2222 then 0x3333_4444 -> reg1=0x3333_2222; rready low 3 cycles mid-read -> data held.
//   - areset pulse during W_DATA beat 2 of 4 -> all regs 0, no bvalid, awready=1 after release; new burst completes normally.

Source files
------------

// File: rtl/axi_regs_pkg.sv
// axi_regs_pkg: shared burst, response and FSM state types for the AXI burst register bank
package axi_regs_pkg;
  typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11} burst_e;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;
endpackage

// File: rtl/axi_burst_regfile_if.sv
// axi_burst_regfile_if: AXI4 AW/W/B/AR/R channel bundle with master and slave views
interface axi_burst_regfile_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH = 4
);
  logic [ID_WIDTH-1:0] awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0] awlen;
  logic [1:0] awburst;
  logic awvalid;
  logic awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic wlast;
  logic wvalid;
  logic wready;
  logic [ID_WIDTH-1:0] bid;
  logic [1:0] bresp;
  logic bvalid;
  logic bready;
  logic [ID_WIDTH-1:0] arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0] arlen;
  logic [1:0] arburst;
  logic arvalid;
  logic arready;
  logic [ID_WIDTH-1:0] rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0] rresp;
  logic rlast;
  logic rvalid;
  logic rready;
  modport master (
    output awid, awaddr, awlen, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arburst, arvalid, rready,
    input awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input awid, awaddr, awlen, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
          arid, araddr, arlen, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: next word index and burst legality; WRAP support only with AXI_REGS_WRAP_EN
module axi_burst_addr_gen import axi_regs_pkg::*; #(
  parameter int IW = 30
) (
  input  logic [IW-1:0] cur,
  input  burst_e        burst,
  input  logic [7:0]    len,
  output logic [IW-1:0] nxt,
  output logic          bad
);
`ifdef AXI_REGS_WRAP_EN
  logic [IW-1:0] mask;
  logic [IW-1:0] base;
  logic wrap_ok;
  assign wrap_ok = len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15;
  assign mask = IW'(len[3:0]);
  assign base = cur & ~mask;
  always_comb begin
    nxt = burst == FIXED ? cur : burst == INCR ? cur + 1'b1 : base | ((cur + 1'b1) & mask);
    bad = burst == RSVD || (burst == WRAP && !wrap_ok);
  end
`else
  logic unused_len;
  assign unused_len = ^len;
  always_comb begin
    nxt = burst == INCR ? cur + 1'b1 : cur;
    bad = burst == RSVD || burst == WRAP;
  end
`endif
endmodule

// File: rtl/axi_burst_regfile.sv
// axi_burst_regfile: AXI4 slave register bank with FIXED/INCR bursts, WRAP bursts when AXI_REGS_WRAP_EN is defined
module axi_burst_regfile import axi_regs_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int REG_COUNT = 8,
  parameter int ID_WIDTH = 4
) (
  input logic clk,
  input logic areset,
  axi_burst_regfile_if.slave bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW = ADDR_WIDTH - OFF;
  localparam int RW = REG_COUNT > 1 ? $clog2(REG_COUNT) : 1;
  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  wr_state_e ws, ws_n;
  rd_state_e rs, rs_n;
  logic [IW-1:0] w_idx, w_nxt, r_idx, r_cur, r_nxt, r_ld;
  logic [7:0] w_len, w_cnt, r_len, r_cnt, r_len_cur;
  burst_e w_burst, r_burst, r_burst_cur;
  logic w_bad, w_err, w_beat_err, w_hs, r_bad, r_ld_en, r_ld_err;
  logic unused;
  assign unused = ^{bus.wlast, bus.awaddr[OFF-1:0], bus.araddr[OFF-1:0]};
  axi_burst_addr_gen #(.IW(IW)) u_wgen (.cur(w_idx), .burst(w_burst), .len(w_len), .nxt(w_nxt), .bad(w_bad));
  assign w_hs = ws == W_DATA && bus.wvalid;
  assign w_beat_err = w_bad || w_idx >= IW'(REG_COUNT);
  // In R_IDLE the generator sees the incoming AR so beat 0 can be fetched on the handshake edge
  assign r_cur = rs == R_IDLE ? bus.araddr[ADDR_WIDTH-1:OFF] : r_idx;
  assign r_burst_cur = rs == R_IDLE ? burst_e'(bus.arburst) : r_burst;
  assign r_len_cur = rs == R_IDLE ? bus.arlen : r_len;
  axi_burst_addr_gen #(.IW(IW)) u_rgen (.cur(r_cur), .burst(r_burst_cur), .len(r_len_cur), .nxt(r_nxt), .bad(r_bad));
  assign r_ld = rs == R_IDLE ? r_cur : r_nxt;
  assign r_ld_err = r_bad || r_ld >= IW'(REG_COUNT);
  assign r_ld_en = rs == R_IDLE ? bus.arvalid : bus.rready && r_cnt != r_len;
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      ws <= W_IDLE;
      rs <= R_IDLE;
    end else begin
      ws <= ws_n;
      rs <= rs_n;
    end
  end
  always_comb begin
    bus.awready = ws == W_IDLE;
    bus.wready = ws == W_DATA;
    bus.bvalid = ws == W_RESP;
    bus.arready = rs == R_IDLE;
    bus.rvalid = rs == R_DATA;
    bus.rlast = rs == R_DATA && r_cnt == r_len;
    ws_n = ws == W_IDLE && bus.awvalid ? W_DATA
         : w_hs && w_cnt == w_len ? W_RESP
         : ws == W_RESP && bus.bready ? W_IDLE : ws;
    rs_n = rs == R_IDLE && bus.arvalid ? R_DATA
         : rs == R_DATA && bus.rready && r_cnt == r_len ? R_IDLE : rs;
  end
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      w_idx <= '0;
      w_len <= '0;
      w_cnt <= '0;
      w_burst <= FIXED;
      w_err <= 1'b0;
      bus.bid <= '0;
      bus.bresp <= RESP_OKAY;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      if (ws == W_IDLE && bus.awvalid) begin
        w_idx <= bus.awaddr[ADDR_WIDTH-1:OFF];
        w_len <= bus.awlen;
        w_burst <= burst_e'(bus.awburst);
        w_cnt <= '0;
        w_err <= 1'b0;
        bus.bid <= bus.awid;
      end
      if (w_hs) begin
        w_idx <= w_nxt;
        w_cnt <= w_cnt + 8'd1;
        w_err <= w_err | w_beat_err;
        if (w_cnt == w_len) bus.bresp <= w_err || w_beat_err ? RESP_SLVERR : RESP_OKAY;
        if (!w_beat_err)
          for (int b = 0; b < NB; b++)
            if (bus.wstrb[b]) regs[w_idx[RW-1:0]][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end
  // Read data is registered from the array, so a same-cycle write is seen on the following beat
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_idx <= '0;
      r_len <= '0;
      r_cnt <= '0;
      r_burst <= FIXED;
      bus.rid <= '0;
      bus.rdata <= '0;
      bus.rresp <= RESP_OKAY;
    end else begin
      if (r_ld_en) begin
        r_idx <= r_ld;
        bus.rdata <= r_ld_err ? '0 : regs[r_ld[RW-1:0]];
        bus.rresp <= r_ld_err ? RESP_SLVERR : RESP_OKAY;
      end
      if (rs == R_IDLE && bus.arvalid) begin
        r_len <= bus.arlen;
        r_burst <= burst_e'(bus.arburst);
        r_cnt <= '0;
        bus.rid <= bus.arid;
      end else if (rs == R_DATA && bus.rready) r_cnt <= r_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_axi_burst_regfile.sv
// tb_axi_burst_regfile: directed bursts checked against a word-level model of the register bank
module tb_axi_burst_regfile;
`ifdef AXI_REGS_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif
  typedef struct {logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last;} rbeat_t;
  typedef struct {logic [3:0] id; logic [1:0] resp;} bbeat_t;
  logic clk = 1'b0;
  logic areset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] model [8];
  rbeat_t exp_r [$];
  bbeat_t exp_b [$];
  logic [31:0] wd [16];
  logic [3:0] wsb [16];
  logic [31:0] got_d [16];
  logic [1:0] got_r [16];
  logic [1:0] last_bresp;
  axi_burst_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4)) bus ();
  axi_burst_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_COUNT(8), .ID_WIDTH(4)) dut (
    .clk(clk), .areset(areset), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for handshake, got none expected one", name);
  endtask
  function automatic bit burst_ok(input logic [1:0] burst, input logic [7:0] len);
    return burst == 2'd0 || burst == 2'd1 ||
           (burst == 2'd2 && WRAP_EN && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction
  function automatic logic [29:0] word_at(input logic [31:0] addr, input logic [7:0] len,
                                          input logic [1:0] burst, input int k);
    logic [29:0] w, base;
    int n;
    w = addr[31:2];
    n = int'(len) + 1;
    base = w - 30'(int'(w) % n);
    if (burst == 2'd0) return w;
    if (burst == 2'd2) return base + 30'((int'(w - base) + k) % n);
    return w + 30'(k);
  endfunction
  always @(negedge clk) begin
    if (!areset && bus.bvalid) begin
      if (exp_b.size() == 0) chk("b_unexpected", 32'(bus.bvalid), 32'd0);
      else begin
        chk("b_id", 32'(bus.bid), 32'(exp_b[0].id));
        chk("b_resp", 32'(bus.bresp), 32'(exp_b[0].resp));
        if (bus.bready) void'(exp_b.pop_front());
      end
    end
    if (!areset && bus.rvalid) begin
      if (exp_r.size() == 0) chk("r_unexpected", 32'(bus.rvalid), 32'd0);
      else begin
        chk("r_id", 32'(bus.rid), 32'(exp_r[0].id));
        chk("r_data", bus.rdata, exp_r[0].data);
        chk("r_resp", 32'(bus.rresp), 32'(exp_r[0].resp));
        chk("r_last", 32'(bus.rlast), 32'(exp_r[0].last));
        if (bus.rready) void'(exp_r.pop_front());
      end
    end
  end
  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst);
    bit err;
    logic [29:0] w;
    int t;
    err = !burst_ok(burst, len);
    for (int k = 0; k <= int'(len); k++) begin
      w = word_at(addr, len, burst, k);
      if (!burst_ok(burst, len) || w >= 30'd8) err = 1'b1;
      else for (int b = 0; b < 4; b++) if (wsb[k][b]) model[w[2:0]][8*b +: 8] = wd[k][8*b +: 8];
    end
    exp_b.push_back(bbeat_t'{id, err ? 2'b10 : 2'b00});
    bus.awid = id;
    bus.awaddr = addr;
    bus.awlen = len;
    bus.awburst = burst;
    bus.awvalid = 1'b1;
    t = 0;
    while (!bus.awready && t < 20) begin @(posedge clk); #1; t++; end
    if (t == 20) timeout("aw_ready");
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      bus.wdata = wd[k];
      bus.wstrb = wsb[k];
      bus.wlast = k == int'(len);
      bus.wvalid = 1'b1;
      chk("w_ready", 32'(bus.wready), 32'd1);
      @(posedge clk); #1;
    end
    bus.wvalid = 1'b0;
    bus.wlast = 1'b0;
    chk("b_valid_after_last", 32'(bus.bvalid), 32'd1);
    last_bresp = bus.bresp;
    t = 0;
    while (!bus.awready && t < 20) begin @(posedge clk); #1; t++; end
    if (t == 20) timeout("w_idle");
  endtask
  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int stall_at);
    logic [29:0] w;
    bit ok;
    int t;
    for (int k = 0; k <= int'(len); k++) begin
      w = word_at(addr, len, burst, k);
      ok = burst_ok(burst, len) && w < 30'd8;
      exp_r.push_back(rbeat_t'{id, ok ? model[w[2:0]] : 32'd0, ok ? 2'b00 : 2'b10, k == int'(len)});
    end
    bus.arid = id;
    bus.araddr = addr;
    bus.arlen = len;
    bus.arburst = burst;
    bus.arvalid = 1'b1;
    t = 0;
    while (!bus.arready && t < 20) begin @(posedge clk); #1; t++; end
    if (t == 20) timeout("ar_ready");
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    chk("r_valid_after_ar", 32'(bus.rvalid), 32'd1);
    for (int k = 0; k <= int'(len); k++) begin
      if (k == stall_at) begin
        bus.rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.rready = 1'b1;
      end
      t = 0;
      while (!bus.rvalid && t < 20) begin @(posedge clk); #1; t++; end
      if (t == 20) timeout("r_valid");
      got_d[k] = bus.rdata;
      got_r[k] = bus.rresp;
      @(posedge clk); #1;
    end
    chk("r_valid_after_last", 32'(bus.rvalid), 32'd0);
  endtask
  initial begin
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 32'(bus.awready), 32'd1);
    chk("rst_arready", 32'(bus.arready), 32'd1);
    chk("rst_wready", 32'(bus.wready), 32'd0);
    chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_rlast", 32'(bus.rlast), 32'd0);
    chk("rst_bid", 32'(bus.bid), 32'd0);
    chk("rst_rid", 32'(bus.rid), 32'd0);
    chk("rst_bresp", 32'(bus.bresp), 32'd0);
    chk("rst_rresp", 32'(bus.rresp), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    areset = 1'b0;
    for (int k = 0; k < 4; k++) begin wd[k] = 32'(k + 1); wsb[k] = 4'hF; end
    axi_write(4'd5, 32'h0, 8'd3, 2'd1);
    chk("incr_bresp", 32'(last_bresp), 32'd0);
    axi_read(4'd6, 32'h0, 8'd3, 2'd1, -1);
    for (int k = 0; k < 4; k++) chk("incr_rdata", got_d[k], 32'(k + 1));
    wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wd[3] = 32'hD;
    axi_write(4'd3, 32'h8, 8'd3, 2'd2);
    chk("wrap_bresp", 32'(last_bresp), WRAP_EN ? 32'd0 : 32'd2);
    axi_read(4'd4, 32'h0, 8'd3, 2'd1, -1);
    chk("wrap_reg0", got_d[0], WRAP_EN ? 32'hC : 32'd1);
    chk("wrap_reg1", got_d[1], WRAP_EN ? 32'hD : 32'd2);
    chk("wrap_reg2", got_d[2], WRAP_EN ? 32'hA : 32'd3);
    chk("wrap_reg3", got_d[3], WRAP_EN ? 32'hB : 32'd4);
    axi_read(4'd4, 32'h8, 8'd3, 2'd2, -1);
    wd[0] = 32'h77; wd[1] = 32'h88;
    axi_write(4'd2, 32'h1C, 8'd1, 2'd1);
    chk("oob_bresp", 32'(last_bresp), 32'd2);
    axi_read(4'd1, 32'h1C, 8'd0, 2'd1, -1);
    chk("oob_reg7", got_d[0], 32'h77);
    axi_read(4'd1, 32'h20, 8'd0, 2'd1, -1);
    chk("oob_rdata", got_d[0], 32'd0);
    chk("oob_rresp", 32'(got_r[0]), 32'd2);
    wd[0] = 32'h1111_2222; wsb[0] = 4'h3; wd[1] = 32'h3333_4444; wsb[1] = 4'hC;
    axi_write(4'd7, 32'h4, 8'd1, 2'd0);
    chk("fixed_bresp", 32'(last_bresp), 32'd0);
    axi_read(4'd0, 32'h4, 8'd0, 2'd1, -1);
    chk("fixed_reg1", got_d[0], 32'h3333_2222);
    axi_read(4'd8, 32'h0, 8'd3, 2'd1, 2);
    chk("stall_beat1", got_d[1], 32'h3333_2222);
    chk("stall_beat2", got_d[2], WRAP_EN ? 32'hA : 32'd3);
    axi_read(4'd12, 32'h4, 8'd2, 2'd0, -1);
    wd[0] = 32'hDEAD; wd[1] = 32'hBEEF; wsb[0] = 4'hF; wsb[1] = 4'hF;
    axi_write(4'd9, 32'h0, 8'd1, 2'd3);
    chk("rsvd_bresp", 32'(last_bresp), 32'd2);
    axi_read(4'd9, 32'h0, 8'd1, 2'd3, -1);
    chk("rsvd_rdata", got_d[0], 32'd0);
    chk("rsvd_rresp", 32'(got_r[1]), 32'd2);
    axi_read(4'd10, 32'h0, 8'd2, 2'd2, -1);
    chk("wrap_badlen_rresp", 32'(got_r[1]), 32'd2);
    axi_read(4'd11, 32'hFFFF_FFFC, 8'd1, 2'd1, -1);
    chk("addr_wrap_top_rresp", 32'(got_r[0]), 32'd2);
    chk("addr_wrap_zero_rresp", 32'(got_r[1]), 32'd0);
    chk("addr_wrap_zero_rdata", got_d[1], WRAP_EN ? 32'hC : 32'd1);
    @(posedge clk); #1;
    bus.awid = 4'd15; bus.awaddr = 32'h0; bus.awlen = 8'd3; bus.awburst = 2'd1; bus.awvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    bus.wdata = 32'h9; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(posedge clk); #1;
    #2;
    areset = 1'b1;
    bus.wvalid = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = '0;
    exp_b.delete();
    @(posedge clk); #1;
    areset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_bvalid", 32'(bus.bvalid), 32'd0);
    end
    chk("abort_awready", 32'(bus.awready), 32'd1);
    for (int k = 0; k < 4; k++) begin wd[k] = 32'(k + 5); wsb[k] = 4'hF; end
    axi_write(4'd13, 32'h10, 8'd3, 2'd1);
    chk("post_abort_bresp", 32'(last_bresp), 32'd0);
    axi_read(4'd14, 32'h0, 8'd7, 2'd1, -1);
    chk("post_abort_reg0", got_d[0], 32'd0);
    chk("post_abort_reg4", got_d[4], 32'd5);
    chk("post_abort_reg7", got_d[7], 32'd8);
    repeat (2) @(posedge clk);
    #1;
    chk("exp_b_drained", 32'(exp_b.size()), 32'd0);
    chk("exp_r_drained", 32'(exp_r.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
